// File: rtl/vga_timing_gen.sv
// Purpose : scans a VGA raster, presents (x, y) to a pixel source and drives
//           hsync/vsync/rgb/active aligned to the returned 1-bit pixel, plus a
//           one-cycle frame_tick at the start of vertical blanking.
// Latency : x/y come straight from the counters; hsync/vsync/rgb/active for a
//           coordinate appear PIX_LAT+1 cycles after it is presented.
// Backpr. : none; free-running raster. The pixel source must answer in exactly
//           PIX_LAT cycles.
// Ports   : clk (pixel clock), rst (sync, active-high), pixel (in),
//           x[9:0], y[8:0], hsync, vsync, rgb[5:0], active, frame_tick (out).
module vga_timing_gen #(
  parameter int         H_ACTIVE = 640,
  parameter int         H_FP     = 16,
  parameter int         H_SYNC   = 96,
  parameter int         H_BP     = 48,
  parameter int         V_ACTIVE = 480,
  parameter int         V_FP     = 10,
  parameter int         V_SYNC   = 2,
  parameter int         V_BP     = 33,
  parameter bit         SYNC_POL = 1'b0,
  parameter int         PIX_LAT  = 1,
  parameter logic [5:0] FG_COLOR = 6'b111111,
  parameter logic [5:0] BG_COLOR = 6'b000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pixel,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic [5:0] rgb,
  output logic       active,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Boundaries are held at 11 bits so a total of exactly 1024 still compares
  // correctly against the zero-extended 10-bit counters.
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic [10:0] h_ext;
  logic [10:0] v_ext;

  assign h_ext = {1'b0, h_cnt};
  assign v_ext = {1'b0, v_cnt};

  // Raster counters. Wrap with >= so a mis-sized parameter set can never run
  // the counter past its last legal value.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_ext >= H_LAST) begin
      h_cnt <= '0;
      if (v_ext >= V_LAST) begin
        v_cnt <= '0;
      end else begin
        v_cnt <= v_cnt + 10'd1;
      end
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  assign x = h_cnt;
  assign y = (v_ext < V_VIS) ? v_cnt[8:0] : 9'd0;

  // Raw timing decoded from the counters in the current cycle.
  logic vis_r;
  logic hs_r;
  logic vs_r;
  logic tick_r;

  always_comb begin
    vis_r  = (h_ext < H_VIS) && (v_ext < V_VIS);
    hs_r   = (h_ext >= HS_START) && (h_ext < HS_END);
    vs_r   = (v_ext >= VS_START) && (v_ext < VS_END);
    // Counters sitting at (0, V_ACTIVE): first cycle of vertical blanking.
    tick_r = (h_ext < 11'd1) && (v_ext >= V_VIS) && (v_ext < V_VIS + 11'd1);
  end

  // Delay line matching the pixel source latency. Bit order {vis, hs, vs};
  // all-zero is the blank / deasserted state.
  logic [2:0] raw_t;
  logic [2:0] dly_t;

  assign raw_t = {vis_r, hs_r, vs_r};

  if (PIX_LAT == 0) begin : g_no_dly
    assign dly_t = raw_t;
  end else begin : g_dly
    logic [2:0] stage [PIX_LAT];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < PIX_LAT; i++) begin
          stage[i] <= 3'b000;
        end
      end else begin
        stage[0] <= raw_t;
        for (int i = 1; i < PIX_LAT; i++) begin
          stage[i] <= stage[i-1];
        end
      end
    end

    assign dly_t = stage[PIX_LAT-1];
  end

  logic vis_d;
  logic hs_d;
  logic vs_d;

  assign vis_d = dly_t[2];
  assign hs_d  = dly_t[1];
  assign vs_d  = dly_t[0];

  // Output register: captures the pixel together with its delayed timing so
  // colour and syncs leave the block on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb        <= 6'b000000;
      active     <= 1'b0;
      hsync      <= ~SYNC_POL;
      vsync      <= ~SYNC_POL;
      frame_tick <= 1'b0;
    end else begin
      rgb        <= vis_d ? (pixel ? FG_COLOR : BG_COLOR) : 6'b000000;
      active     <= vis_d;
      hsync      <= hs_d ? SYNC_POL : ~SYNC_POL;
      vsync      <= vs_d ? SYNC_POL : ~SYNC_POL;
      frame_tick <= tick_r;
    end
  end

endmodule
